cdb_arb_multi: RTL and testbench
================================

// Module: cdb_arb_multi
// PURPOSE
//  Parametrised common-data-bus arbiter: collects completion requests from NUM_SRC execution
//  units and broadcasts up to NUM_CDB results per cycle on registered CDB lanes to RS/ROB/RAT.
//  Supports fixed or round-robin priority and a flush that squashes in-flight grants.
//  Sits between the EXU writeback ports (ALU, MDU, LSU, ...) and the CDB consumers.
// PARAMETERS
//  NUM_SRC   3   number of requesting execution units (>=1)
//  NUM_CDB   1   number of CDB broadcast lanes (1..NUM_SRC)
//  TAG_W     4   tag width (ROB/physical-register tag)
//  DATA_W    32  result data width
//  ARB_MODE  1   0 = fixed priority (index 0 highest), 1 = round-robin
// PORTS
//  clk        in   1               clock
//  rst        in   1               synchronous active-high reset
//  flush      in   1               squash: no grants this cycle, lanes cleared next cycle
//  src_req    in   NUM_SRC         per-source result-valid request
//  src_tag    in   NUM_SRC*TAG_W   per-source tag, source i at [i*TAG_W +: TAG_W]
//  src_wdata  in   NUM_SRC*DATA_W  per-source result data, packed as src_tag
//  src_rdy    out  NUM_SRC         per-source grant (combinational, same cycle as req)
//  cdb_wr     out  NUM_CDB         per-lane broadcast valid (registered)
//  cdb_tag    out  NUM_CDB*TAG_W   per-lane tag (registered)
//  cdb_wdata  out  NUM_CDB*DATA_W  per-lane data (registered)
// BEHAVIOUR
//  - One clock, clk; rst synchronous active-high. On rst: cdb_wr/cdb_tag/cdb_wdata=0, rr_ptr=0.
//  - Handshake: source transfer occurs in cycle where src_req[i]&&src_rdy[i]; source holds
//    req/tag/wdata stable until granted. src_rdy[i]=0 whenever src_req[i]=0, flush=1, or rst=1.
//  - Priority order: ARB_MODE=0 -> 0,1,..,NUM_SRC-1; ARB_MODE=1 -> rr_ptr, rr_ptr+1, .. mod NUM_SRC.
//  - Grant: first min(NUM_CDB, #requesters) requesters in priority order granted; the k-th
//    granted source (k=0..) maps to lane k. Ungranted requesters see src_rdy=0 and retry.
//  - Latency: 1 cycle. Lane k registers wr=1, tag, wdata of its granted source at the next edge;
//    lanes with no grant register wr=0, tag=0, wdata=0 (idle lanes always drive zeros).
//  - No downstream backpressure: CDB consumers always accept; each lane valid for exactly 1 cycle.
//  - rr_ptr (clog2(NUM_SRC) bits, min 1): when ARB_MODE=1 and >=1 grant, rr_ptr <= (index of
//    last-granted source + 1) mod NUM_SRC; unchanged when no grant, on flush, or ARB_MODE=0.
//    Wrap: last-granted = NUM_SRC-1 -> rr_ptr=0.
//  - Fairness (RR): a continuously requesting source is granted within ceil(NUM_SRC/NUM_CDB)
//    cycles.
//  - flush: when flush=1 no src_rdy asserted; next edge all lanes cleared to 0, rr_ptr held. A
//    result broadcast in the same edge flush is sampled (granted previous cycle) is still driven
//    that cycle; consumers qualify it with their own flush.
//  - rst has priority over flush; rst mid-stream drops all pending requests without grant.
//  - NUM_SRC=1, NUM_CDB=1 degenerates to a registered pass-through with src_rdy=src_req.
//  - No tag uniqueness check; two lanes may carry equal tags if sources present them.
// TESTING (NUM_SRC=3, NUM_CDB=1, ARB_MODE=0 unless noted)
//  1 Reset: rst=1 2 cycles with all src_req=1 -> src_rdy=000, cdb_wr=0, tag=0, wdata=0.
//  2 Fixed prio: req=111 tags 1,2,3 held -> src_rdy=001; cdb_wr=1 tag=1 next cycle; drop req0 ->
//    tag 2 then tag 3 broadcast on consecutive cycles; cdb_wr=0 after.
//  3 RR (ARB_MODE=1): req=111 held 6 cycles -> grants 0,1,2,0,1,2; rr_ptr wraps 2->0.
//  4 Multi-lane (NUM_CDB=2, ARB_MODE=1): req=111 -> cycle0 grants src0->lane0, src1->lane1;
//    cycle1 src2->lane0, src0->lane1, cdb_wr=11 both cycles.
//  5 Flush: req=011 with flush=1 one cycle -> src_rdy=000, next cdb_wr=0, rr_ptr unchanged; flush
//    released -> src0 (tag 0xA, data 0xDEADBEEF) broadcast one cycle later.
//  6 Idle: all req=0 10 cycles -> cdb_wr=0, tag/wdata=0, rr_ptr constant.

Source files
------------

// File: rtl/cdb_arb_multi.sv
// cdb_arb_multi: common-data-bus arbiter.
// Collects completion requests from NUM_SRC execution units. Up to NUM_CDB of them are
// granted each cycle and broadcast on registered CDB lanes to the RS/ROB/RAT consumers.
// The priority order is either fixed (index 0 highest) or round-robin.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               squash: no grants this cycle, lanes idle next cycle
//   src_req/tag/wdata   per-source request, tag and data (source i at [i*W +: W])
//   src_rdy             per-source grant, combinational in the request cycle
//   cdb_wr/tag/wdata    per-lane registered broadcast (idle lanes drive zeros)
module cdb_arb_multi #(
  parameter int NUM_SRC  = 3,
  parameter int NUM_CDB  = 1,
  parameter int TAG_W    = 4,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_req,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
  input  logic [NUM_SRC*DATA_W-1:0] src_wdata,
  output logic [NUM_SRC-1:0]        src_rdy,
  output logic [NUM_CDB-1:0]        cdb_wr,
  output logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
  output logic [NUM_CDB*DATA_W-1:0] cdb_wdata
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [PTR_W-1:0]          rr_ptr;
  logic [PTR_W-1:0]          rr_ptr_nxt;
  logic [NUM_SRC-1:0]        grant;
  logic [NUM_CDB-1:0]        lane_vld;
  logic [NUM_CDB*TAG_W-1:0]  lane_tag;
  logic [NUM_CDB*DATA_W-1:0] lane_data;
  logic                      any_grant;
  int                        base;
  int                        pos  [NUM_SRC];
  int                        rank [NUM_SRC];
  int                        last_pos;
  int                        last_src;

  always_comb begin
    base = (ARB_MODE == 1) ? int'(rr_ptr) : 0;

    // pos[i]: place of source i in this cycle's priority order (0 = highest)
    for (int i = 0; i < NUM_SRC; i++) begin
      pos[i] = (i >= base) ? (i - base) : (i - base + NUM_SRC);
    end

    // rank[i]: number of requesters ahead of source i; it is also the lane it lands on
    for (int i = 0; i < NUM_SRC; i++) begin
      rank[i] = 0;
      for (int j = 0; j < NUM_SRC; j++) begin
        if (src_req[j] && (pos[j] < pos[i])) begin
          rank[i] = rank[i] + 1;
        end
      end
    end

    grant    = '0;
    last_pos = -1;
    last_src = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!rst && !flush && src_req[i] && (rank[i] < NUM_CDB)) begin
        grant[i] = 1'b1;
        if (pos[i] > last_pos) begin
          last_pos = pos[i];
          last_src = i;
        end
      end
    end

    lane_vld  = '0;
    lane_tag  = '0;
    lane_data = '0;
    for (int l = 0; l < NUM_CDB; l++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (grant[i] && (rank[i] == l)) begin
          lane_vld[l]                      = 1'b1;
          lane_tag[l*TAG_W +: TAG_W]       = src_tag[i*TAG_W +: TAG_W];
          lane_data[l*DATA_W +: DATA_W]    = src_wdata[i*DATA_W +: DATA_W];
        end
      end
    end

    any_grant  = |grant;
    rr_ptr_nxt = (last_src == NUM_SRC - 1) ? '0 : PTR_W'(last_src + 1);
  end

  assign src_rdy = grant;

  // flush already suppresses every grant, so the lanes fall to zero without a separate clear
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_wr    <= '0;
      cdb_tag   <= '0;
      cdb_wdata <= '0;
      rr_ptr    <= '0;
    end else begin
      cdb_wr    <= lane_vld;
      cdb_tag   <= lane_tag;
      cdb_wdata <= lane_data;
      if ((ARB_MODE == 1) && any_grant) begin
        rr_ptr <= rr_ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arb_multi.sv
module tb_cdb_arb_multi;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // f: fixed priority, 3 sources, 1 lane
  logic [2:0]  f_req, f_rdy;
  logic [11:0] f_tag;
  logic [95:0] f_data;
  logic [0:0]  f_wr;
  logic [3:0]  f_ctag;
  logic [31:0] f_cdata;
  // r: round-robin, 3 sources, 1 lane
  logic [2:0]  r_req, r_rdy;
  logic [11:0] r_tag;
  logic [95:0] r_data;
  logic [0:0]  r_wr;
  logic [3:0]  r_ctag;
  logic [31:0] r_cdata;
  // m: round-robin, 3 sources, 2 lanes
  logic [2:0]  m_req, m_rdy;
  logic [11:0] m_tag;
  logic [95:0] m_data;
  logic [1:0]  m_wr;
  logic [7:0]  m_ctag;
  logic [63:0] m_cdata;
  // d: degenerate 1 source, 1 lane
  logic [0:0]  d_req, d_rdy;
  logic [3:0]  d_tag;
  logic [31:0] d_data;
  logic [0:0]  d_wr;
  logic [3:0]  d_ctag;
  logic [31:0] d_cdata;

  cdb_arb_multi #(.NUM_SRC(3), .NUM_CDB(1), .TAG_W(4), .DATA_W(32), .ARB_MODE(0)) u_f (
    .clk(clk), .rst(rst), .flush(flush), .src_req(f_req), .src_tag(f_tag), .src_wdata(f_data),
    .src_rdy(f_rdy), .cdb_wr(f_wr), .cdb_tag(f_ctag), .cdb_wdata(f_cdata));

  cdb_arb_multi #(.NUM_SRC(3), .NUM_CDB(1), .TAG_W(4), .DATA_W(32), .ARB_MODE(1)) u_r (
    .clk(clk), .rst(rst), .flush(flush), .src_req(r_req), .src_tag(r_tag), .src_wdata(r_data),
    .src_rdy(r_rdy), .cdb_wr(r_wr), .cdb_tag(r_ctag), .cdb_wdata(r_cdata));

  cdb_arb_multi #(.NUM_SRC(3), .NUM_CDB(2), .TAG_W(4), .DATA_W(32), .ARB_MODE(1)) u_m (
    .clk(clk), .rst(rst), .flush(flush), .src_req(m_req), .src_tag(m_tag), .src_wdata(m_data),
    .src_rdy(m_rdy), .cdb_wr(m_wr), .cdb_tag(m_ctag), .cdb_wdata(m_cdata));

  cdb_arb_multi #(.NUM_SRC(1), .NUM_CDB(1), .TAG_W(4), .DATA_W(32), .ARB_MODE(1)) u_d (
    .clk(clk), .rst(rst), .flush(flush), .src_req(d_req), .src_tag(d_tag), .src_wdata(d_data),
    .src_rdy(d_rdy), .cdb_wr(d_wr), .cdb_tag(d_ctag), .cdb_wdata(d_cdata));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset held two cycles with every source requesting
    rst = 1'b1; flush = 1'b0;
    f_req = '1; r_req = '1; m_req = '1; d_req = '1;
    f_tag = {4'd3, 4'd2, 4'd1}; f_data = {32'h303, 32'h202, 32'h101};
    r_tag = {4'd3, 4'd2, 4'd1}; r_data = {32'h303, 32'h202, 32'h101};
    m_tag = {4'd3, 4'd2, 4'd1}; m_data = {32'h303, 32'h202, 32'h101};
    d_tag = 4'h7; d_data = 32'h77;
    tick(); tick();
    chk("rst_f_rdy", f_rdy, 0);
    chk("rst_m_rdy", m_rdy, 0);
    chk("rst_d_rdy", d_rdy, 0);
    chk("rst_f_wr", f_wr, 0);
    chk("rst_f_tag", f_ctag, 0);
    chk("rst_f_data", f_cdata, 0);
    chk("rst_m_wr", m_wr, 0);
    chk("rst_m_data", m_cdata, 0);
    f_req = '0; r_req = '0; m_req = '0; d_req = '0;
    rst = 1'b0;
    tick();

    // fixed priority
    f_req = 3'b111; #1;
    chk("fx_rdy0", f_rdy, 3'b001);
    tick();
    chk("fx_wr0", f_wr, 1); chk("fx_tag0", f_ctag, 1); chk("fx_data0", f_cdata, 32'h101);
    f_req = 3'b110; #1;
    chk("fx_rdy1", f_rdy, 3'b010);
    tick();
    chk("fx_wr1", f_wr, 1); chk("fx_tag1", f_ctag, 2); chk("fx_data1", f_cdata, 32'h202);
    f_req = 3'b100; #1;
    chk("fx_rdy2", f_rdy, 3'b100);
    tick();
    chk("fx_wr2", f_wr, 1); chk("fx_tag2", f_ctag, 3); chk("fx_data2", f_cdata, 32'h303);
    f_req = 3'b000; #1;
    chk("fx_rdy3", f_rdy, 3'b000);
    tick();
    chk("fx_wr3", f_wr, 0); chk("fx_tag3", f_ctag, 0); chk("fx_data3", f_cdata, 0);

    // a broadcast registered before a flush still appears; the flush cycle itself grants nothing
    f_req = 3'b001; #1;
    tick();
    f_req = 3'b010; flush = 1'b1; #1;
    chk("fxfl_wr_kept", f_wr, 1);
    chk("fxfl_tag_kept", f_ctag, 1);
    chk("fxfl_rdy", f_rdy, 0);
    tick();
    chk("fxfl_wr_clr", f_wr, 0);
    chk("fxfl_tag_clr", f_ctag, 0);
    flush = 1'b0; f_req = 3'b000;

    // round-robin, continuous request: grants 0,1,2,0,1,2
    r_req = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("rr_rdy", r_rdy, 3'b001 << (c % 3));
      tick();
      chk("rr_wr", r_wr, 1);
      chk("rr_tag", r_ctag, (c % 3) + 1);
    end

    // flush on RR instance, pointer back at 0 after the wrap
    r_tag = {4'd0, 4'd5, 4'hA}; r_data = {32'h0, 32'h55, 32'hDEADBEEF};
    r_req = 3'b011; flush = 1'b1; #1;
    chk("fl_rdy", r_rdy, 0);
    tick();
    chk("fl_wr", r_wr, 0); chk("fl_tag", r_ctag, 0); chk("fl_data", r_cdata, 0);
    flush = 1'b0; #1;
    chk("fl_rel_rdy", r_rdy, 3'b001);
    tick();
    chk("fl_rel_wr", r_wr, 1); chk("fl_rel_tag", r_ctag, 4'hA); chk("fl_rel_data", r_cdata, 32'hDEADBEEF);
    r_req = 3'b000;

    // idle for 10 cycles; RR pointer must stay at 1
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_r_wr", r_wr, 0);
      chk("idle_r_tag", r_ctag, 0);
      chk("idle_r_data", r_cdata, 0);
    end
    r_req = 3'b111; #1;
    chk("idle_ptr_rdy", r_rdy, 3'b010);
    tick();
    chk("idle_ptr_tag", r_ctag, 5);
    r_req = 3'b000;

    // two lanes, round-robin
    m_req = 3'b111; #1;
    chk("ml_rdy0", m_rdy, 3'b011);
    tick();
    chk("ml_wr0", m_wr, 2'b11); chk("ml_tag0", m_ctag, 8'h21); chk("ml_data0", m_cdata, {32'h202, 32'h101});
    #1;
    chk("ml_rdy1", m_rdy, 3'b101);
    tick();
    chk("ml_wr1", m_wr, 2'b11); chk("ml_tag1", m_ctag, 8'h13); chk("ml_data1", m_cdata, {32'h101, 32'h303});
    #1;
    chk("ml_rdy2", m_rdy, 3'b110);
    tick();
    chk("ml_wr2", m_wr, 2'b11); chk("ml_tag2", m_ctag, 8'h32); chk("ml_data2", m_cdata, {32'h303, 32'h202});
    m_req = 3'b001; #1;
    chk("ml_rdy3", m_rdy, 3'b001);
    tick();
    chk("ml_wr3", m_wr, 2'b01); chk("ml_tag3", m_ctag, 8'h01); chk("ml_data3", m_cdata, {32'h0, 32'h101});
    m_req = 3'b000; #1;
    chk("ml_rdy4", m_rdy, 0);
    tick();
    chk("ml_wr4", m_wr, 0); chk("ml_tag4", m_ctag, 0); chk("ml_data4", m_cdata, 0);

    // single-source pass-through
    d_req = 1'b1; #1;
    chk("deg_rdy1", d_rdy, 1);
    tick();
    chk("deg_wr1", d_wr, 1); chk("deg_tag1", d_ctag, 4'h7); chk("deg_data1", d_cdata, 32'h77);
    d_req = 1'b0; #1;
    chk("deg_rdy0", d_rdy, 0);
    tick();
    chk("deg_wr0", d_wr, 0);

    // reset mid-stream drops the pending request
    f_req = 3'b111; #1;
    chk("mrst_rdy_pre", f_rdy, 3'b001);
    rst = 1'b1; #1;
    chk("mrst_rdy", f_rdy, 0);
    tick();
    chk("mrst_wr", f_wr, 0); chk("mrst_tag", f_ctag, 0);
    rst = 1'b0; f_req = 3'b000;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
